// File: rtl/flag_sequencer.sv
// Status-flag owner: decodes ALU opcodes into flag write masks, commits one cycle late,
// answers branch-condition queries and keeps a save/restore stack of flag snapshots.
module flag_sequencer #(
    parameter int OP_W        = 5,
    parameter int STACK_DEPTH = 4
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            alu_valid,
    input  logic [OP_W-1:0] alu_op,
    input  logic            z_in,
    input  logic            c_in,
    input  logic            s_in,
    input  logic            o_in,
    input  logic            cond_req,
    input  logic [3:0]      cond_code,
    output logic            cond_ack,
    output logic            cond_true,
    input  logic            save_req,
    input  logic            restore_req,
    output logic            stack_empty,
    output logic            stack_full,
    output logic            stack_err,
    output logic [3:0]      zcso
);

    localparam int DW = $clog2(STACK_DEPTH + 1);
    localparam int IW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] CHECK = 2'd1;
    localparam logic [1:0] ACK   = 2'd2;

    // Flag vectors are ordered [0]=Z [1]=C [2]=S [3]=O throughout.
    function automatic logic [3:0] decodeMask(input logic [OP_W-1:0] op);
        logic [31:0] v;
        logic [3:0]  m;
        v = 32'(op);
        case (v) inside
            32'd0, 32'd1, 32'd3, 32'd4, 32'd5, 32'd6: m = 4'b1111;
            32'd8, 32'd9:                             m = 4'b0111;
            32'd17, 32'd18, [32'd20:32'd30]:          m = 4'b0101;
            default:                                  m = 4'b0000;
        endcase
        return m;
    endfunction

    function automatic logic [3:0] usedFlags(input logic [3:0] code);
        logic [3:0] u;
        case (code)
            4'd1, 4'd2:   u = 4'b0001;
            4'd3, 4'd4:   u = 4'b0010;
            4'd5, 4'd6:   u = 4'b0100;
            4'd7, 4'd8:   u = 4'b1000;
            4'd9, 4'd10:  u = 4'b1100;
            4'd11, 4'd12: u = 4'b1101;
            default:      u = 4'b0000;
        endcase
        return u;
    endfunction

    function automatic logic evalCond(input logic [3:0] f, input logic [3:0] code);
        logic r;
        case (code)
            4'd0:    r = 1'b1;
            4'd1:    r = f[0];
            4'd2:    r = !f[0];
            4'd3:    r = f[1];
            4'd4:    r = !f[1];
            4'd5:    r = f[2];
            4'd6:    r = !f[2];
            4'd7:    r = f[3];
            4'd8:    r = !f[3];
            4'd9:    r = (f[2] == f[3]);
            4'd10:   r = (f[2] != f[3]);
            4'd11:   r = !f[0] && (f[2] == f[3]);
            4'd12:   r = f[0] || (f[2] != f[3]);
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    logic [3:0]    aluMask;
    logic          pendValid;
    logic [3:0]    pendMask;
    logic [3:0]    pendFlags;
    logic [3:0]    zcsoNext;
    logic [3:0]    stackMem [STACK_DEPTH];
    logic [DW-1:0] depth;
    logic [IW-1:0] topIdx;
    logic [IW-1:0] pushIdx;
    logic          doPush;
    logic          doPop;
    logic          errNow;
    logic [1:0]    state;
    logic [1:0]    stateNext;
    logic          hazard;
    logic          resolve;
    logic [3:0]    condUsed;

    assign aluMask     = decodeMask(alu_op);
    assign stack_empty = (depth == '0);
    assign stack_full  = (depth == DW'(STACK_DEPTH));
    assign topIdx      = IW'(depth - DW'(1));
    assign pushIdx     = IW'(depth);

    assign doPush = save_req && !restore_req && !stack_full;
    assign doPop  = restore_req && !save_req && !stack_empty;
    assign errNow = (save_req && restore_req)
                  || (save_req && !restore_req && stack_full)
                  || (restore_req && !save_req && stack_empty);

    // A restore wins over the pending commit; saves see the post-commit value.
    always_comb begin
        zcsoNext = zcso;
        if (doPop) begin
            zcsoNext = stackMem[topIdx];
        end else if (pendValid) begin
            zcsoNext = (zcso & ~pendMask) | (pendFlags & pendMask);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            zcso      <= 4'b0000;
            pendValid <= 1'b0;
            pendMask  <= 4'b0000;
            pendFlags <= 4'b0000;
            depth     <= '0;
            stack_err <= 1'b0;
        end else begin
            zcso      <= zcsoNext;
            pendValid <= alu_valid && !doPop;
            pendMask  <= aluMask;
            pendFlags <= {o_in, s_in, c_in, z_in};
            stack_err <= errNow;
            if (doPush) begin
                depth <= depth + DW'(1);
            end else if (doPop) begin
                depth <= depth - DW'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset && doPush) begin
            stackMem[pushIdx] <= zcsoNext;
        end
    end

    // A query waits while any in-flight write touches a flag its condition reads.
    assign condUsed = usedFlags(cond_code);
    assign hazard   = (pendValid && ((pendMask & condUsed) != 4'b0000))
                   || (alu_valid && ((aluMask & condUsed) != 4'b0000));
    assign resolve  = (state == CHECK) && cond_req && !hazard;

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (cond_req) stateNext = CHECK;
            CHECK: begin
                if (!cond_req) begin
                    stateNext = IDLE;
                end else if (!hazard) begin
                    stateNext = ACK;
                end
            end
            ACK:     stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            cond_true <= 1'b0;
        end else begin
            state     <= stateNext;
            cond_true <= resolve && evalCond(zcsoNext, cond_code);
        end
    end

    assign cond_ack = (state == ACK);

endmodule

// File: tb/tb_flag_sequencer.sv
// Self-checking bench for flag_sequencer: table-driven commit and condition vectors
// with scoreboard queues, plus hand-written hazard, cancel, stack and reset sequences.
module tb_flag_sequencer;

    logic       clock = 1'b0;
    logic       reset;
    logic       alu_valid;
    logic [4:0] alu_op;
    logic       z_in, c_in, s_in, o_in;
    logic       cond_req;
    logic [3:0] cond_code;
    logic       cond_ack;
    logic       cond_true;
    logic       save_req;
    logic       restore_req;
    logic       stack_empty;
    logic       stack_full;
    logic       stack_err;
    logic [3:0] zcso;

    typedef struct {
        logic [4:0] op;
        logic [3:0] flags;
        logic [3:0] expZcso;
    } AluVec;

    typedef struct {
        logic [3:0] code;
        logic       expTrue;
    } CondVec;

    int   checkCount = 0;
    int   failCount  = 0;
    logic [3:0] zcsoQ[$];
    logic       condQ[$];

    flag_sequencer #(.OP_W(5), .STACK_DEPTH(4)) dut (
        .clock       (clock),
        .reset       (reset),
        .alu_valid   (alu_valid),
        .alu_op      (alu_op),
        .z_in        (z_in),
        .c_in        (c_in),
        .s_in        (s_in),
        .o_in        (o_in),
        .cond_req    (cond_req),
        .cond_code   (cond_code),
        .cond_ack    (cond_ack),
        .cond_true   (cond_true),
        .save_req    (save_req),
        .restore_req (restore_req),
        .stack_empty (stack_empty),
        .stack_full  (stack_full),
        .stack_err   (stack_err),
        .zcso        (zcso)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus(input logic valid, input logic [4:0] op, input logic [3:0] flags);
        alu_valid = valid;
        alu_op    = op;
        {o_in, s_in, c_in, z_in} = flags;
    endtask

    task automatic setFlags(input logic [3:0] v);
        applyStimulus(1'b1, 5'b00000, v);
        tick();
        alu_valid = 1'b0;
        tick();
    endtask

    // Expected cond_true goes into the scoreboard; the ack monitor pops it.
    task automatic issueQuery(input logic [3:0] code, input logic expTrue, input int expLatency, input string name);
        int   cycles;
        logic dummy;
        condQ.push_back(expTrue);
        cond_code = code;
        cond_req  = 1'b1;
        cycles    = 0;
        do begin
            tick();
            alu_valid = 1'b0;
            cycles++;
        end while (cond_ack !== 1'b1 && cycles < 20);
        cond_req = 1'b0;
        if (cond_ack !== 1'b1) begin
            checkCount++;
            failCount++;
            $display("[TB] FAIL %s_timeout: got no ack expected ack within 20 cycles", name);
            dummy = condQ.pop_back();
        end else begin
            checkOutput({name, "_latency"}, cycles, expLatency);
        end
        tick();
    endtask

    always @(negedge clock) begin
        if (cond_ack === 1'b1) begin
            if (condQ.size() == 0) begin
                checkCount++;
                failCount++;
                $display("[TB] FAIL unexpected_ack: got cond_ack=1 expected cond_ack=0");
            end else begin
                checkOutput("cond_true", cond_true, condQ.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        AluVec      aluVecs[13];
        CondVec     condVecsA[16];
        CondVec     condVecsB[8];
        logic [15:0] expA;
        logic [3:0] stackVals[4];

        aluVecs[0]  = '{5'b00000, 4'b1111, 4'b1111};
        aluVecs[1]  = '{5'b10001, 4'b0000, 4'b1010};
        aluVecs[2]  = '{5'b01000, 4'b0001, 4'b1001};
        aluVecs[3]  = '{5'b00111, 4'b1111, 4'b1001};
        aluVecs[4]  = '{5'b10100, 4'b0100, 4'b1100};
        aluVecs[5]  = '{5'b11110, 4'b0001, 4'b1001};
        aluVecs[6]  = '{5'b11111, 4'b0110, 4'b1001};
        aluVecs[7]  = '{5'b00110, 4'b0110, 4'b0110};
        aluVecs[8]  = '{5'b10011, 4'b1001, 4'b0110};
        aluVecs[9]  = '{5'b01001, 4'b1010, 4'b0010};
        aluVecs[10] = '{5'b10010, 4'b1101, 4'b0111};
        aluVecs[11] = '{5'b10000, 4'b0000, 4'b0111};
        aluVecs[12] = '{5'b00011, 4'b1000, 4'b1000};

        // Expected results of codes 0..15 with only S set.
        expA = 16'b0001_0101_0011_0101;
        for (int i = 0; i < 16; i++) condVecsA[i] = '{4'(i), expA[i]};

        condVecsB[0] = '{4'd1,  1'b1};
        condVecsB[1] = '{4'd2,  1'b0};
        condVecsB[2] = '{4'd3,  1'b0};
        condVecsB[3] = '{4'd7,  1'b1};
        condVecsB[4] = '{4'd8,  1'b0};
        condVecsB[5] = '{4'd9,  1'b0};
        condVecsB[6] = '{4'd11, 1'b0};
        condVecsB[7] = '{4'd12, 1'b1};

        stackVals[0] = 4'b0011;
        stackVals[1] = 4'b0101;
        stackVals[2] = 4'b1010;
        stackVals[3] = 4'b1100;

        reset = 1'b1;
        applyStimulus(1'b0, 5'b00000, 4'b0000);
        cond_req = 1'b0;
        cond_code = 4'd0;
        save_req = 1'b0;
        restore_req = 1'b0;
        tick();
        tick();
        checkOutput("reset_zcso", zcso, 4'b0000);
        checkOutput("reset_empty", stack_empty, 1'b1);
        checkOutput("reset_full", stack_full, 1'b0);
        checkOutput("reset_ack", cond_ack, 1'b0);
        checkOutput("reset_true", cond_true, 1'b0);
        checkOutput("reset_err", stack_err, 1'b0);
        reset = 1'b0;
        tick();

        // Back-to-back commits; each edge commits the previous op.
        for (int i = 0; i < 13; i++) begin
            applyStimulus(1'b1, aluVecs[i].op, aluVecs[i].flags);
            zcsoQ.push_back(aluVecs[i].expZcso);
            tick();
            if (i > 0) checkOutput($sformatf("commit_%0d", i - 1), zcso, zcsoQ.pop_front());
        end
        alu_valid = 1'b0;
        tick();
        checkOutput("commit_12", zcso, zcsoQ.pop_front());

        setFlags(4'b0100);
        for (int i = 0; i < 16; i++) issueQuery(condVecsA[i].code, condVecsA[i].expTrue, 2, $sformatf("condA_%0d", i));
        setFlags(4'b1001);
        for (int i = 0; i < 8; i++) issueQuery(condVecsB[i].code, condVecsB[i].expTrue, 2, $sformatf("condB_%0d", i));

        // Z write in flight on the query cycle delays the ack by one.
        setFlags(4'b0000);
        applyStimulus(1'b1, 5'b00001, 4'b0001);
        issueQuery(4'd1, 1'b1, 3, "hazard_z");
        checkOutput("hazard_zcso", zcso, 4'b0001);
        applyStimulus(1'b1, 5'b01000, 4'b0000);
        issueQuery(4'd7, 1'b0, 2, "nohazard_o");

        // Query dropped while stalled never acks.
        applyStimulus(1'b1, 5'b00000, 4'b0001);
        cond_code = 4'd1;
        cond_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("cancel_hold", cond_ack, 1'b0);
        end
        cond_req = 1'b0;
        tick();
        alu_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("cancel_no_ack", cond_ack, 1'b0);
        end

        for (int k = 0; k < 4; k++) begin
            setFlags(stackVals[k]);
            save_req = 1'b1;
            tick();
            save_req = 1'b0;
            checkOutput("push_err", stack_err, 1'b0);
        end
        checkOutput("full_after_4", stack_full, 1'b1);
        checkOutput("empty_after_4", stack_empty, 1'b0);
        setFlags(4'b0000);
        save_req = 1'b1;
        tick();
        save_req = 1'b0;
        checkOutput("overflow_err", stack_err, 1'b1);
        checkOutput("overflow_full", stack_full, 1'b1);
        tick();
        checkOutput("overflow_err_clear", stack_err, 1'b0);
        for (int k = 3; k >= 0; k--) begin
            restore_req = 1'b1;
            tick();
            restore_req = 1'b0;
            checkOutput($sformatf("pop_%0d", k), zcso, stackVals[k]);
        end
        checkOutput("empty_after_pops", stack_empty, 1'b1);
        restore_req = 1'b1;
        tick();
        restore_req = 1'b0;
        checkOutput("underflow_err", stack_err, 1'b1);
        checkOutput("underflow_zcso", zcso, 4'b0011);
        tick();
        checkOutput("underflow_err_clear", stack_err, 1'b0);

        // Save in the commit cycle captures the value being committed.
        applyStimulus(1'b1, 5'b00000, 4'b0110);
        tick();
        alu_valid = 1'b0;
        save_req = 1'b1;
        tick();
        save_req = 1'b0;
        setFlags(4'b1111);
        restore_req = 1'b1;
        tick();
        restore_req = 1'b0;
        checkOutput("save_with_commit", zcso, 4'b0110);

        save_req = 1'b1;
        tick();
        save_req = 1'b0;
        setFlags(4'b1001);
        save_req = 1'b1;
        restore_req = 1'b1;
        tick();
        save_req = 1'b0;
        restore_req = 1'b0;
        checkOutput("both_err", stack_err, 1'b1);
        checkOutput("both_zcso", zcso, 4'b1001);
        checkOutput("both_empty", stack_empty, 1'b0);
        checkOutput("both_full", stack_full, 1'b0);
        tick();
        checkOutput("both_err_clear", stack_err, 1'b0);
        restore_req = 1'b1;
        tick();
        restore_req = 1'b0;
        checkOutput("both_depth_kept", zcso, 4'b0110);
        checkOutput("both_empty_after", stack_empty, 1'b1);

        // Reset lands on the commit edge of an in-flight op and an open query.
        save_req = 1'b1;
        tick();
        save_req = 1'b0;
        applyStimulus(1'b1, 5'b00000, 4'b1111);
        cond_code = 4'd0;
        cond_req = 1'b1;
        tick();
        alu_valid = 1'b0;
        reset = 1'b1;
        tick();
        checkOutput("midreset_zcso", zcso, 4'b0000);
        checkOutput("midreset_ack", cond_ack, 1'b0);
        checkOutput("midreset_empty", stack_empty, 1'b1);
        cond_req = 1'b0;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("postreset_ack", cond_ack, 1'b0);
            checkOutput("postreset_zcso", zcso, 4'b0000);
        end

        checkOutput("cond_queue_drained", condQ.size(), 0);
        checkOutput("zcso_queue_drained", zcsoQ.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
